// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   // Sequencer states; the encoding 2'd3 is unused and behaves as RUN.
   typedef enum logic [1:0] {
      PC_RUN      = 2'd0,
      PC_MEM_WAIT = 2'd1,
      PC_MD_WAIT  = 2'd2
   } pc_state_e;

   localparam int XLEN_DEF       = 32;
   localparam int MD_TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_reg;

   // Count up on each enabled cycle and stick at all-ones.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_reg <= '0;
      end else if (inc_i && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken branches, multi-cycle mul/div and load-use hazards.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             loaduse_hazard_i,
   input  logic             branch_taken_i,
   input  logic [XLEN-1:0]  branch_target_i,
   input  logic             md_req_i,
   input  logic             md_done_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             stall_ex_o,
   output logic             stall_mem_o,
   output logic             flush_id_o,
   output logic             flush_ex_o,
   output logic             bubble_mem_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             md_start_o,
   output logic             md_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // md_cnt only has to reach MD_TIMEOUT-1 before the wait is abandoned.
   localparam int MDC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

   pc_state_e        state_reg, state_next;
   logic [MDC_W-1:0] md_cnt_reg, md_cnt_next;
   logic             md_timeout_reg;
   logic             set_timeout;

   // State, mul/div wait counter and sticky abort flag.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg      <= PC_RUN;
         md_cnt_reg     <= '0;
         md_timeout_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         md_cnt_reg     <= md_cnt_next;
         md_timeout_reg <= md_timeout_reg | set_timeout;
      end
   end

   // Next state and per-stage controls; one action per cycle in RUN.
   always_comb begin
      state_next    = state_reg;
      md_cnt_next   = md_cnt_reg;
      set_timeout   = 1'b0;
      stall_if_o    = 1'b0;
      stall_id_o    = 1'b0;
      stall_ex_o    = 1'b0;
      stall_mem_o   = 1'b0;
      flush_id_o    = 1'b0;
      flush_ex_o    = 1'b0;
      bubble_mem_o  = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      md_start_o    = 1'b0;
      case (state_reg)
         PC_MEM_WAIT: begin
            // EX is frozen behind MEM, so other hazard inputs are ignored.
            if (mem_ready_i) begin
               state_next = PC_RUN;
            end else begin
               stall_if_o  = 1'b1;
               stall_id_o  = 1'b1;
               stall_ex_o  = 1'b1;
               stall_mem_o = 1'b1;
            end
         end
         PC_MD_WAIT: begin
            md_cnt_next = md_cnt_reg + MDC_W'(1);
            if (md_done_i) begin
               // Result is valid now: let EX advance this cycle.
               state_next = PC_RUN;
            end else if (md_cnt_reg == MD_LAST) begin
               set_timeout = 1'b1;
               state_next  = PC_RUN;
            end else begin
               stall_if_o   = 1'b1;
               stall_id_o   = 1'b1;
               stall_ex_o   = 1'b1;
               bubble_mem_o = 1'b1;
            end
         end
         default: begin
            // RUN, and any illegal encoding recovers through here.
            state_next = PC_RUN;
            if (mem_req_i && !mem_ready_i) begin
               stall_if_o  = 1'b1;
               stall_id_o  = 1'b1;
               stall_ex_o  = 1'b1;
               stall_mem_o = 1'b1;
               state_next  = PC_MEM_WAIT;
            end else if (branch_taken_i) begin
               // Load-use from a wrong-path instruction is moot: it is flushed.
               redirect_o    = 1'b1;
               redirect_pc_o = branch_target_i;
               flush_id_o    = 1'b1;
               flush_ex_o    = 1'b1;
            end else if (md_req_i) begin
               md_start_o   = 1'b1;
               stall_if_o   = 1'b1;
               stall_id_o   = 1'b1;
               stall_ex_o   = 1'b1;
               bubble_mem_o = 1'b1;
               md_cnt_next  = '0;
               state_next   = PC_MD_WAIT;
            end else if (loaduse_hazard_i) begin
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end
         end
      endcase
   end

   assign md_timeout_o = md_timeout_reg;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (stall_if_o),
      .cnt_o   (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (redirect_o),
      .cnt_o   (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for single-cycle behaviour and
// hand-written sequences for mul/div, timeout, memory wait, reset and saturation.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lu = 1'b0, br = 1'b0, mdreq = 1'b0, mddone = 1'b0;
   logic        memreq = 1'b0, memrdy = 1'b0;
   logic [31:0] tgt = '0;

   // Main instance (MD_TIMEOUT=64)
   logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, bub, redir, mds, mdto;
   logic [31:0] rpc, scnt, fcnt;
   // Short-timeout instance (MD_TIMEOUT=8), same stimulus
   logic        b_s_if, b_s_id, b_s_ex, b_s_mem, b_f_id, b_f_ex, b_bub, b_redir, b_mds, b_mdto;
   logic [31:0] b_rpc, b_scnt, b_fcnt;
   // Small counter for the saturation boundary
   logic        sat_inc = 1'b0;
   logic [2:0]  sat_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.XLEN(32), .MD_TIMEOUT(64), .CNT_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .loaduse_hazard_i(lu), .branch_taken_i(br),
      .branch_target_i(tgt), .md_req_i(mdreq), .md_done_i(mddone), .mem_req_i(memreq),
      .mem_ready_i(memrdy), .stall_if_o(s_if), .stall_id_o(s_id), .stall_ex_o(s_ex),
      .stall_mem_o(s_mem), .flush_id_o(f_id), .flush_ex_o(f_ex), .bubble_mem_o(bub),
      .redirect_o(redir), .redirect_pc_o(rpc), .md_start_o(mds), .md_timeout_o(mdto),
      .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
   );

   pipe_ctrl #(.XLEN(32), .MD_TIMEOUT(8), .CNT_W(32)) dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .loaduse_hazard_i(lu), .branch_taken_i(br),
      .branch_target_i(tgt), .md_req_i(mdreq), .md_done_i(mddone), .mem_req_i(memreq),
      .mem_ready_i(memrdy), .stall_if_o(b_s_if), .stall_id_o(b_s_id), .stall_ex_o(b_s_ex),
      .stall_mem_o(b_s_mem), .flush_id_o(b_f_id), .flush_ex_o(b_f_ex), .bubble_mem_o(b_bub),
      .redirect_o(b_redir), .redirect_pc_o(b_rpc), .md_start_o(b_mds), .md_timeout_o(b_mdto),
      .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
   );

   sat_counter #(.CNT_W(3)) u_sat (
      .clk_i(clk), .rst_n_i(rst_n), .inc_i(sat_inc), .cnt_o(sat_cnt)
   );

   // Control bundle: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble, redirect, md_start}
   logic [8:0] outs, b_outs;
   assign outs   = {s_if, s_id, s_ex, s_mem, f_id, f_ex, bub, redir, mds};
   assign b_outs = {b_s_if, b_s_id, b_s_ex, b_s_mem, b_f_id, b_f_ex, b_bub, b_redir, b_mds};

   typedef struct {
      logic        lu, br;
      logic [31:0] tgt;
      logic        mdreq, mddone, memreq, memrdy;
      logic [8:0]  exp;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic l, input logic b, input logic [31:0] t, input logic mq,
                        input logic md, input logic mr, input logic my);
      lu = l; br = b; tgt = t; mdreq = mq; mddone = md; memreq = mr; memrdy = my;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 32'h0, 0, 0, 0, 0);
      sat_inc = 1'b0;
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_scnt, exp_fcnt, nstall, nstart, nredir;
      logic released;

      // RUN-state table; consecutive vectors also walk through MEM_WAIT and MD_WAIT.
      //            lu  br  tgt            mq  md  mr  my  expected        pc
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'b110001000, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'h100,      1'b0, 1'b0, 1'b0, 1'b0, 9'b000011010, 32'h100};
      vecs[3]  = '{1'b0, 1'b1, 32'hDEADBEE0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000011010, 32'hDEADBEE0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 9'b000000000, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 9'b111100000, 32'h0};
      vecs[6]  = '{1'b1, 1'b1, 32'h44,       1'b1, 1'b0, 1'b1, 1'b0, 9'b111100000, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 9'b000000000, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, 32'h48,       1'b1, 1'b0, 1'b0, 1'b0, 9'b000011010, 32'h48};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 9'b111000101, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 32'h4C,       1'b1, 1'b0, 1'b0, 1'b0, 9'b111000100, 32'h0};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 9'b000000000, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'b000000000, 32'h0};
      vecs[13] = '{1'b0, 1'b1, 32'h50,       1'b0, 1'b0, 1'b1, 1'b0, 9'b111100000, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 9'b000000000, 32'h0};
      vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 9'b110001000, 32'h0};

      // Reset state
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_outs", {55'h0, outs}, 64'h0);
      chk("reset_pc", {32'h0, rpc}, 64'h0);
      chk("reset_cnts", {scnt, fcnt}, 64'h0);
      chk("reset_timeout", {63'h0, mdto}, 64'h0);
      $display("reset: outs=%b stall_cnt=%0d flush_cnt=%0d", outs, scnt, fcnt);
      next_cycle();
      rst_n = 1'b1;

      // Table-driven vectors
      exp_scnt = 0;
      exp_fcnt = 0;
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].lu, vecs[i].br, vecs[i].tgt, vecs[i].mdreq, vecs[i].mddone,
               vecs[i].memreq, vecs[i].memrdy);
         @(negedge clk);
         $display("vec %0d: outs=%b pc=%h stall_cnt=%0d flush_cnt=%0d", i, outs, rpc, scnt, fcnt);
         chk($sformatf("vec%0d_outs", i), {55'h0, outs}, {55'h0, vecs[i].exp});
         chk($sformatf("vec%0d_pc", i), {32'h0, rpc}, {32'h0, vecs[i].exp_pc});
         chk($sformatf("vec%0d_stall_cnt", i), {32'h0, scnt}, 64'(exp_scnt));
         chk($sformatf("vec%0d_flush_cnt", i), {32'h0, fcnt}, 64'(exp_fcnt));
         exp_scnt += int'(vecs[i].exp[8]);
         exp_fcnt += int'(vecs[i].exp[1]);
         next_cycle();
      end
      drive(0, 0, 32'h0, 0, 0, 0, 0);
      @(negedge clk);
      chk("table_final_stall_cnt", {32'h0, scnt}, 64'(exp_scnt));
      chk("table_final_flush_cnt", {32'h0, fcnt}, 64'(exp_fcnt));
      next_cycle();

      // DIV: done arrives 33 cycles after the request
      do_reset();
      nstall = 0;
      nstart = 0;
      drive(0, 0, 32'h0, 1, 0, 0, 0);
      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         nstall += int'(s_if);
         nstart += int'(mds);
         next_cycle();
         mdreq = 1'b0;
      end
      mddone = 1'b1;
      @(negedge clk);
      chk("div_release_outs", {55'h0, outs}, 64'h0);
      next_cycle();
      mddone = 1'b0;
      @(negedge clk);
      $display("div: stall_cycles=%0d starts=%0d stall_cnt=%0d timeout=%b", nstall, nstart, scnt, mdto);
      chk("div_stall_cycles", 64'(nstall), 64'd33);
      chk("div_start_pulses", 64'(nstart), 64'd1);
      chk("div_stall_cnt", {32'h0, scnt}, 64'd33);
      chk("div_no_timeout", {63'h0, mdto}, 64'h0);
      chk("div_back_in_run", {55'h0, outs}, 64'h0);
      next_cycle();

      // Timeout on the MD_TIMEOUT=8 instance
      do_reset();
      nstall = 0;
      released = 1'b0;
      drive(0, 0, 32'h0, 1, 0, 0, 0);
      for (int k = 0; k < 20 && !released; k++) begin
         @(negedge clk);
         if (b_s_if) begin
            nstall++;
         end else begin
            released = 1'b1;
            chk("to_abort_cycle_outs", {55'h0, b_outs}, 64'h0);
            chk("to_flag_not_yet", {63'h0, b_mdto}, 64'h0);
         end
         next_cycle();
         mdreq = 1'b0;
      end
      chk("to_release_seen", {63'h0, released}, 64'h1);
      @(negedge clk);
      $display("timeout: stall_cycles=%0d timeout=%b stall_cnt=%0d", nstall, b_mdto, b_scnt);
      chk("to_stall_cycles", 64'(nstall), 64'd8);
      chk("to_flag_set", {63'h0, b_mdto}, 64'h1);
      chk("to_stall_cnt", {32'h0, b_scnt}, 64'd8);
      next_cycle();
      drive(0, 0, 32'h0, 1, 0, 0, 0);
      next_cycle();
      drive(0, 0, 32'h0, 0, 1, 0, 0);
      next_cycle();
      drive(0, 0, 32'h0, 0, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      chk("to_flag_sticky", {63'h0, b_mdto}, 64'h1);
      next_cycle();

      // Memory wait with a taken branch pending
      do_reset();
      nstall = 0;
      nredir = 0;
      drive(0, 1, 32'h200, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (outs == 9'b111100000) nstall++;
         nredir += int'(redir);
         next_cycle();
      end
      memrdy = 1'b1;
      @(negedge clk);
      chk("mem_ready_cycle_outs", {55'h0, outs}, 64'h0);
      next_cycle();
      drive(0, 1, 32'h200, 0, 0, 0, 0);
      @(negedge clk);
      $display("memwait: full_stalls=%0d early_redirects=%0d pc=%h", nstall, nredir, rpc);
      chk("mem_full_stalls", 64'(nstall), 64'd3);
      chk("mem_no_early_redirect", 64'(nredir), 64'd0);
      chk("mem_redirect_outs", {55'h0, outs}, 64'h1A);
      chk("mem_redirect_pc", {32'h0, rpc}, 64'h200);
      next_cycle();

      // Reset asserted while in MD_WAIT
      do_reset();
      drive(0, 0, 32'h0, 1, 0, 0, 0);
      next_cycle();
      mdreq = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("rst_mid_pre_cnt", {32'h0, scnt}, 64'd2);
      chk("rst_mid_pre_stall", {63'h0, s_if}, 64'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      $display("reset mid-wait: outs=%b stall_cnt=%0d flush_cnt=%0d", outs, scnt, fcnt);
      chk("rst_mid_outs", {55'h0, outs}, 64'h0);
      chk("rst_mid_cnts", {scnt, fcnt}, 64'h0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_idle_after", {55'h0, outs}, 64'h0);
      next_cycle();
      mdreq = 1'b1;
      @(negedge clk);
      chk("rst_mid_run_start", {55'h0, outs}, 64'h1C5);
      next_cycle();
      mdreq = 1'b0;

      // Saturation boundary on a 3-bit counter
      do_reset();
      sat_inc = 1'b1;
      for (int k = 0; k < 5; k++) next_cycle();
      @(negedge clk);
      chk("sat_count5", {61'h0, sat_cnt}, 64'd5);
      for (int k = 0; k < 5; k++) next_cycle();
      @(negedge clk);
      chk("sat_hold_max", {61'h0, sat_cnt}, 64'd7);
      sat_inc = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      $display("saturate: cnt=%0d", sat_cnt);
      chk("sat_idle_hold", {61'h0, sat_cnt}, 64'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
